// File: rtl/ntt_pkg.sv
// Shared NTT constants: default modulus, sequence limit, Barrett constants and FSM state type.
package ntt_pkg;

  localparam int unsigned Q     = 3329;
  localparam int unsigned Q_W   = $clog2(Q);
  localparam int unsigned N_MAX = 256;

  // M = floor(2^k / q) with k = 2*ceil(log2(q)); evaluated at elaboration time only
  function automatic longint unsigned barrett_m(input int unsigned q);
    int unsigned k;
    k = 2 * $clog2(q);
    return (64'd1 << k) / 64'(q);
  endfunction

  localparam int unsigned     BARRETT_K = 2 * Q_W;
  localparam longint unsigned BARRETT_M = barrett_m(Q);

  typedef logic [Q_W-1:0] residue_t;

  typedef enum logic [1:0] {
    TW_IDLE,
    TW_EMIT,
    TW_CALC
  } tw_state_e;

endpackage

// File: rtl/twiddle_gen_if.sv
// Control and valid/ready stream bundle between twiddle_gen and its consumer.
interface twiddle_gen_if #(
  parameter int unsigned Q_W   = 12,
  parameter int unsigned CNT_W = 9
);
  logic             start;
  logic [Q_W-1:0]   omega;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic [Q_W-1:0]   tw_data;
  logic [CNT_W-1:0] tw_idx;
  logic             tw_valid;
  logic             tw_ready;
  logic             tw_last;
  logic             done;

  modport slave (
    input  start, omega, count, tw_ready,
    output busy, tw_data, tw_idx, tw_valid, tw_last, done
  );

  modport master (
    output start, omega, count, tw_ready,
    input  busy, tw_data, tw_idx, tw_valid, tw_last, done
  );
endinterface

// File: rtl/mod_mult.sv
// Combinational a*b mod Q via Barrett reduction; exact for any operands below 2^Q_W.
module mod_mult
  import ntt_pkg::*;
#(
  parameter int unsigned Q   = ntt_pkg::Q,
  parameter int unsigned Q_W = $clog2(Q)
) (
  input  logic [Q_W-1:0] a_i,
  input  logic [Q_W-1:0] b_i,
  output logic [Q_W-1:0] r_o
);

  localparam int unsigned   K = 2 * Q_W;
  localparam logic [K-1:0]  M = K'(barrett_m(Q));
  localparam logic [K-1:0]  QK = K'(Q);

  logic [K-1:0]   prod;
  logic [2*K-1:0] prod_m;
  logic [K-1:0]   qhat;
  logic [K-1:0]   r0, r1, r2;

  // qhat underestimates floor(p/Q) by at most 2, so r0 < 3Q before the fix-ups
  always_comb begin
    prod   = K'(a_i) * K'(b_i);
    prod_m = (2*K)'(prod) * (2*K)'(M);
    qhat   = prod_m[2*K-1:K];
    r0     = prod - qhat * QK;
    r1     = (r0 >= QK) ? r0 - QK : r0;
    r2     = (r1 >= QK) ? r1 - QK : r1;
    r_o    = r2[Q_W-1:0];
  end

endmodule

// File: rtl/twiddle_gen.sv
// Emits omega^0..omega^(count-1) mod Q on a valid/ready stream, one power per two cycles max.
module twiddle_gen
  import ntt_pkg::*;
#(
  parameter int unsigned Q     = ntt_pkg::Q,
  parameter int unsigned Q_W   = $clog2(Q),
  parameter int unsigned N_MAX = ntt_pkg::N_MAX,
  parameter int unsigned CNT_W = $clog2(N_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  twiddle_gen_if.slave  bus
);

  tw_state_e        state_q, state_d;
  logic [Q_W-1:0]   cur_q, cur_d;
  logic [Q_W-1:0]   omega_q, omega_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [Q_W-1:0]   next_pow;
  logic             is_last;

  mod_mult #(.Q(Q), .Q_W(Q_W)) u_mm (
    .a_i (cur_q),
    .b_i (omega_q),
    .r_o (next_pow)
  );

  assign is_last = (idx_q == cnt_q - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TW_IDLE;
      cur_q   <= '0;
      omega_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      omega_q <= omega_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    omega_d = omega_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      TW_IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            done_d = 1'b1;
          end else begin
            omega_d = bus.omega;
            cnt_d   = bus.count;
            cur_d   = Q_W'(1);
            idx_d   = '0;
            state_d = TW_EMIT;
          end
        end
      end
      TW_EMIT: begin
        if (bus.tw_ready) begin
          if (is_last) begin
            state_d = TW_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = TW_CALC;
          end
        end
      end
      TW_CALC: begin
        cur_d   = next_pow;
        idx_d   = idx_q + CNT_W'(1);
        state_d = TW_EMIT;
      end
      default: state_d = TW_IDLE;
    endcase
  end

  assign bus.busy     = (state_q != TW_IDLE);
  assign bus.tw_valid = (state_q == TW_EMIT);
  assign bus.tw_last  = (state_q == TW_EMIT) && is_last;
  assign bus.tw_data  = cur_q;
  assign bus.tw_idx   = idx_q;
  assign bus.done     = done_q;

endmodule
